// File: rtl/bht_update_ctrl.sv
// -----------------------------------------------------------------------------
// bht_update_ctrl
//
// Sequencer for the 32-entry, 2-bit saturating-counter branch history table.
// Owns the table's single synchronous read port and single write port:
//   * sweeps every entry to INIT_STATE after reset or a flush,
//   * queues resolved-branch outcomes arriving from MEM/WB,
//   * applies them as read-modify-write updates, yielding the read port to
//     fetch-stage prediction lookups, which always have priority.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   flush_req         one-cycle pulse: drop queued updates and re-sweep
//   init_busy         high while the sweep is running
//   upd_valid/ready   update handshake (upd_addr, upd_taken)
//   fetch_rd_req      lookup request at fetch_rd_addr
//   fetch_pred_valid  registered; fetch_pred holds the counter this cycle
//   tbl_rd_*          table read port (data returns the cycle after rd_en)
//   tbl_wr_*          table write port (commits at the next rising edge)
//   dbg_state         current FSM state, for checkers and debug
//
// Handshake: an update transfers on any rising edge where upd_valid and
// upd_ready are both high. upd_ready never depends on upd_valid; the source
// must hold upd_valid/upd_addr/upd_taken stable until the transfer.
// -----------------------------------------------------------------------------
module bht_update_ctrl #(
   parameter int         IDX_W      = 5,
   parameter int         ENTRIES    = 32,
   parameter int         DEPTH      = 4,
   parameter logic [1:0] INIT_STATE = 2'b01
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_req,
   output logic             init_busy,
   input  logic             upd_valid,
   output logic             upd_ready,
   input  logic [IDX_W-1:0] upd_addr,
   input  logic             upd_taken,
   input  logic             fetch_rd_req,
   input  logic [IDX_W-1:0] fetch_rd_addr,
   output logic             fetch_pred_valid,
   output logic [1:0]       fetch_pred,
   output logic             tbl_rd_en,
   output logic [IDX_W-1:0] tbl_rd_addr,
   input  logic [1:0]       tbl_rd_data,
   output logic             tbl_wr_en,
   output logic [IDX_W-1:0] tbl_wr_addr,
   output logic [1:0]       tbl_wr_data,
   output logic [1:0]       dbg_state
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_RD   = 2'd2,
      ST_WR   = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] sweep_idx;
   logic             sweep_last;

   // Update queue: circular buffer with one extra pointer bit so that
   // full and empty are distinguishable.
   logic [IDX_W-1:0] q_addr  [DEPTH];
   logic             q_taken [DEPTH];
   logic [PTR_W:0]   wr_ptr, rd_ptr, q_count;
   logic             q_full, q_empty, push, pop;
   logic [IDX_W-1:0] head_addr;
   logic             head_taken;

   logic             pred_vld_q;
   logic             byp_q;
   logic [1:0]       byp_data_q;

   function automatic logic [1:0] sat_next(input logic [1:0] c, input logic taken);
      if (taken) return (c == 2'b11) ? 2'b11 : c + 2'b01;
      else       return (c == 2'b00) ? 2'b00 : c - 2'b01;
   endfunction

   assign q_count    = wr_ptr - rd_ptr;
   assign q_full     = (q_count == (PTR_W+1)'(DEPTH));
   assign q_empty    = (q_count == '0);
   assign head_addr  = q_addr[rd_ptr[PTR_W-1:0]];
   assign head_taken = q_taken[rd_ptr[PTR_W-1:0]];
   assign sweep_last = (sweep_idx == IDX_W'(ENTRIES-1));

   assign upd_ready  = !q_full && (state != ST_INIT) && !flush_req;
   assign push       = upd_valid && upd_ready;
   assign init_busy  = (state == ST_INIT);
   assign dbg_state  = state;

   // Next state, table port control and queue pop.
   always_comb begin
      state_nxt   = state;
      tbl_rd_en   = 1'b0;
      tbl_rd_addr = fetch_rd_addr;
      tbl_wr_en   = 1'b0;
      tbl_wr_addr = sweep_idx;
      tbl_wr_data = INIT_STATE;
      pop         = 1'b0;

      if (fetch_rd_req && (state != ST_INIT)) begin
         tbl_rd_en   = 1'b1;
         tbl_rd_addr = fetch_rd_addr;
      end

      case (state)
         ST_INIT: begin
            tbl_wr_en = 1'b1;
            if (sweep_last) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (!q_empty) state_nxt = ST_RD;
         end
         ST_RD: begin
            // Fetch owns the read port; the update waits here until it is free.
            if (!fetch_rd_req) begin
               tbl_rd_en   = 1'b1;
               tbl_rd_addr = head_addr;
               state_nxt   = ST_WR;
            end
         end
         ST_WR: begin
            tbl_wr_en   = 1'b1;
            tbl_wr_addr = head_addr;
            tbl_wr_data = sat_next(tbl_rd_data, head_taken);
            pop         = 1'b1;
            // Head leaves now; a push this cycle keeps the pipeline busy.
            if ((q_count > (PTR_W+1)'(1)) || push) state_nxt = ST_RD;
            else                                   state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_INIT;
      endcase

      if (flush_req) begin
         state_nxt = ST_INIT;
         pop       = 1'b0;
         if (state == ST_WR) tbl_wr_en = 1'b0;
      end

      // While reset is held the FSM sits in INIT; keep the table untouched.
      if (reset) tbl_wr_en = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_INIT;
         sweep_idx <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         state <= state_nxt;
         if (flush_req) begin
            sweep_idx <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
         end else begin
            // Wraps back to 0 after the last entry, ready for the next sweep.
            if (state == ST_INIT) sweep_idx <= sweep_idx + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Queue payload needs no reset: entries are only read behind the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr[PTR_W-1:0]]  <= upd_addr;
         q_taken[wr_ptr[PTR_W-1:0]] <= upd_taken;
      end
   end

   // Lookup result tracking. A write landing on the looked-up index in the
   // request cycle is captured so the stale read-before-write data is replaced.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pred_vld_q <= 1'b0;
         byp_q      <= 1'b0;
         byp_data_q <= INIT_STATE;
      end else begin
         pred_vld_q <= fetch_rd_req && (state != ST_INIT) && !flush_req;
         byp_q      <= tbl_wr_en && (tbl_wr_addr == fetch_rd_addr);
         byp_data_q <= tbl_wr_data;
      end
   end

   assign fetch_pred_valid = pred_vld_q;
   assign fetch_pred       = (state == ST_INIT) ? INIT_STATE :
                             (byp_q ? byp_data_q : tbl_rd_data);

endmodule

// File: tb/tb_bht_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bht_update_ctrl
//
// Bench for bht_update_ctrl. A synchronous read-before-write RAM stands in for
// the table. A reference model tracks counter contents, the expected order of
// update writes (exp_q), sweep progress and lookup results; one compare
// process checks the DUT against it on every falling edge. Directed tests add
// hand-computed literal expectations from a write log.
// -----------------------------------------------------------------------------
module tb_bht_update_ctrl;

   localparam int         IDX_W   = 5;
   localparam int         ENTRIES = 32;
   localparam int         DEPTH   = 4;
   localparam logic [1:0] INIT_ST = 2'b01;

   // ---------------- clock / reset ----------------
   logic             clk;
   logic             reset;
   logic             flush_req;
   logic             init_busy;
   logic             upd_valid;
   logic             upd_ready;
   logic [IDX_W-1:0] upd_addr;
   logic             upd_taken;
   logic             fetch_rd_req;
   logic [IDX_W-1:0] fetch_rd_addr;
   logic             fetch_pred_valid;
   logic [1:0]       fetch_pred;
   logic             tbl_rd_en;
   logic [IDX_W-1:0] tbl_rd_addr;
   logic [1:0]       tbl_rd_data;
   logic             tbl_wr_en;
   logic [IDX_W-1:0] tbl_wr_addr;
   logic [1:0]       tbl_wr_data;
   logic [1:0]       dbg_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bht_update_ctrl #(
      .IDX_W(IDX_W), .ENTRIES(ENTRIES), .DEPTH(DEPTH), .INIT_STATE(INIT_ST)
   ) dut (
      .clk(clk), .reset(reset), .flush_req(flush_req), .init_busy(init_busy),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
      .upd_taken(upd_taken), .fetch_rd_req(fetch_rd_req),
      .fetch_rd_addr(fetch_rd_addr), .fetch_pred_valid(fetch_pred_valid),
      .fetch_pred(fetch_pred), .tbl_rd_en(tbl_rd_en), .tbl_rd_addr(tbl_rd_addr),
      .tbl_rd_data(tbl_rd_data), .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
      .tbl_wr_data(tbl_wr_data), .dbg_state(dbg_state)
   );

   // Table RAM: read returns the pre-write contents when both hit one index.
   logic [1:0] mem [ENTRIES];
   always @(posedge clk) begin
      if (tbl_wr_en) mem[tbl_wr_addr] <= tbl_wr_data;
      if (tbl_rd_en) tbl_rd_data <= mem[tbl_rd_addr];
   end

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // ---------------- bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   function automatic logic [1:0] sat_ref(input logic [1:0] c, input logic taken);
      int v;
      v = int'(c) + (taken ? 1 : -1);
      if (v > 3) v = 3;
      if (v < 0) v = 0;
      return v[1:0];
   endfunction

   typedef struct {
      logic [IDX_W-1:0] a;
      logic [1:0]       d;
      int               c;
   } wrec_t;
   wrec_t wlog[$];

   // ---------------- reference model ----------------
   logic [IDX_W+1:0] exp_q[$];        // {addr, data} of update writes, in order
   logic [1:0]       spec_tbl  [ENTRIES];  // contents once every queued update lands
   logic [1:0]       committed [ENTRIES];  // contents as of writes already made
   int               init_left = 0;
   int               sweep_exp = 0;
   logic             pend_v    = 1'b0;
   logic [1:0]       pend_d    = 2'b00;

   task automatic model_restart();
      for (int i = 0; i < ENTRIES; i++) begin
         spec_tbl[i]  = INIT_ST;
         committed[i] = INIT_ST;
      end
      exp_q.delete();
      init_left = ENTRIES;
      sweep_exp = 0;
   endtask

   // ---------------- scoreboard / compare ----------------
   always @(negedge clk) begin
      logic             exp_ready;
      logic [IDX_W+1:0] e;
      logic [1:0]       nv;
      if (tbl_wr_en) wlog.push_back('{a: tbl_wr_addr, d: tbl_wr_data, c: cyc_cnt});
      if (reset) begin
         check("rst_wr_en", tbl_wr_en, 0);
         check("rst_init_busy", init_busy, 1);
         check("rst_upd_ready", upd_ready, 0);
         check("rst_pred_valid", fetch_pred_valid, 0);
         check("rst_pred", fetch_pred, INIT_ST);
         model_restart();
         pend_v = 1'b0;
      end else begin
         check("pred_valid", fetch_pred_valid, pend_v);
         if (pend_v) check("pred_value", fetch_pred, pend_d);
         if (init_left > 0) begin
            check("init_busy", init_busy, 1);
            check("init_upd_ready", upd_ready, 0);
            check("init_wr_en", tbl_wr_en, 1);
            check("init_wr_addr", tbl_wr_addr, sweep_exp);
            check("init_wr_data", tbl_wr_data, INIT_ST);
            check("init_pred", fetch_pred, INIT_ST);
            pend_v = 1'b0;
            if (flush_req) model_restart();
            else begin
               init_left--;
               sweep_exp++;
            end
         end else begin
            exp_ready = (exp_q.size() < DEPTH) && !flush_req;
            check("init_busy", init_busy, 0);
            check("upd_ready", upd_ready, exp_ready);
            if (flush_req) check("flush_wr_en", tbl_wr_en, 0);
            else if (tbl_wr_en) begin
               if (exp_q.size() == 0) check("unexpected_write", tbl_wr_en, 0);
               else begin
                  e = exp_q.pop_front();
                  check("upd_wr_addr", tbl_wr_addr, e[IDX_W+1:2]);
                  check("upd_wr_data", tbl_wr_data, e[1:0]);
                  committed[e[IDX_W+1:2]] = e[1:0];
               end
            end
            if (!flush_req && upd_valid && exp_ready) begin
               nv = sat_ref(spec_tbl[upd_addr], upd_taken);
               spec_tbl[upd_addr] = nv;
               exp_q.push_back({upd_addr, nv});
            end
            // A lookup returns the table as it stands after this cycle's write.
            pend_v = fetch_rd_req && !flush_req;
            pend_d = committed[fetch_rd_addr];
            if (flush_req) model_restart();
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int addr, input logic taken);
      upd_valid = 1'b1;
      upd_addr  = IDX_W'(addr);
      upd_taken = taken;
      cyc();
      upd_valid = 1'b0;
   endtask

   task automatic check_log(input string name, input int idx, input int addr, input logic [1:0] data);
      if (idx >= wlog.size()) check({name, "_missing"}, wlog.size(), idx + 1);
      else begin
         check({name, "_addr"}, wlog[idx].a, addr);
         check({name, "_data"}, wlog[idx].d, data);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      reset = 1'b1;
      flush_req = 1'b0;
      upd_valid = 1'b0;
      upd_addr = '0;
      upd_taken = 1'b0;
      fetch_rd_req = 1'b0;
      fetch_rd_addr = '0;
      repeat (3) cyc();

      // 1: sweep after reset
      wlog.delete();
      reset = 1'b0;
      repeat (ENTRIES) cyc();
      check("sweep_count", wlog.size(), ENTRIES);
      for (int i = 0; i < ENTRIES; i++) check_log("sweep", i, i, 2'b01);
      @(negedge clk);
      check("sweep_done_busy", init_busy, 0);
      check("sweep_done_ready", upd_ready, 1);

      // 2: idx 5 taken x3 -> 10, 11, 11, two cycles apart
      cyc();
      wlog.delete();
      push(5, 1'b1); push(5, 1'b1); push(5, 1'b1);
      repeat (12) cyc();
      check("idx5_count", wlog.size(), 3);
      check_log("idx5_w0", 0, 5, 2'b10);
      check_log("idx5_w1", 1, 5, 2'b11);
      check_log("idx5_w2", 2, 5, 2'b11);
      if (wlog.size() == 3) begin
         check("idx5_gap0", wlog[1].c - wlog[0].c, 2);
         check("idx5_gap1", wlog[2].c - wlog[1].c, 2);
      end

      // 3: idx 7 NT, NT (no underflow), T, T -> 00, 00, 01, 10
      wlog.delete();
      push(7, 1'b0); push(7, 1'b0); push(7, 1'b1); push(7, 1'b1);
      repeat (14) cyc();
      check("idx7_count", wlog.size(), 4);
      check_log("idx7_w0", 0, 7, 2'b00);
      check_log("idx7_w1", 1, 7, 2'b00);
      check_log("idx7_w2", 2, 7, 2'b01);
      check_log("idx7_w3", 3, 7, 2'b10);

      // 4: fetch idx 3 every cycle stalls four queued updates
      fetch_rd_req  = 1'b1;
      fetch_rd_addr = 5'd3;
      cyc();
      wlog.delete();
      push(3, 1'b1); push(3, 1'b1); push(3, 1'b0); push(3, 1'b1);
      @(negedge clk);
      check("stall_full_ready", upd_ready, 0);
      check("stall_pred_valid", fetch_pred_valid, 1);
      repeat (6) cyc();
      check("stall_no_writes", wlog.size(), 0);
      fetch_rd_req = 1'b0;
      repeat (12) cyc();
      check("idx3_count", wlog.size(), 4);
      check_log("idx3_w0", 0, 3, 2'b10);
      check_log("idx3_w1", 1, 3, 2'b11);
      check_log("idx3_w2", 2, 3, 2'b10);
      check_log("idx3_w3", 3, 3, 2'b11);

      // 5: lookup of idx 9 in the cycle its 11 is written -> bypassed 11
      push(9, 1'b1); push(9, 1'b1);
      cyc(); cyc(); cyc();
      fetch_rd_req  = 1'b1;
      fetch_rd_addr = 5'd9;
      @(negedge clk);
      check("byp_wr_cycle_en", tbl_wr_en, 1);
      check("byp_wr_cycle_data", tbl_wr_data, 2'b11);
      cyc();
      fetch_rd_req = 1'b0;
      @(negedge clk);
      check("byp_pred_valid", fetch_pred_valid, 1);
      check("byp_pred", fetch_pred, 2'b11);
      repeat (4) cyc();

      // 6: flush in a WR cycle with two queued, then a second flush at idx 10
      push(12, 1'b1); push(12, 1'b0);
      cyc();
      flush_req = 1'b1;
      upd_valid = 1'b1;
      upd_addr  = 5'd12;
      upd_taken = 1'b1;
      @(negedge clk);
      check("flush_wr_suppressed", tbl_wr_en, 0);
      check("flush_upd_ready", upd_ready, 0);
      cyc();
      flush_req = 1'b0;
      upd_valid = 1'b0;
      wlog.delete();
      repeat (10) cyc();
      check("flush_sweep_count", wlog.size(), 10);
      for (int i = 0; i < 10; i++) check_log("flush_sweep", i, i, 2'b01);
      flush_req = 1'b1;
      cyc();
      flush_req = 1'b0;
      wlog.delete();
      repeat (ENTRIES) cyc();
      check("reflush_count", wlog.size(), ENTRIES);
      for (int i = 0; i < ENTRIES; i++) check_log("reflush_sweep", i, i, 2'b01);
      @(negedge clk);
      check("reflush_busy", init_busy, 0);

      // 7: reset mid-update, then a fresh update sees the re-swept table
      cyc();
      push(20, 1'b1); push(20, 1'b1);
      cyc();
      reset = 1'b1;
      repeat (3) cyc();
      reset = 1'b0;
      repeat (ENTRIES + 1) cyc();
      wlog.delete();
      push(20, 1'b1);
      repeat (6) cyc();
      check("post_rst_count", wlog.size(), 1);
      check_log("post_rst_w0", 0, 20, 2'b10);

      // Drain: every expected update write must have appeared.
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
      check("drain_pending", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
